// File: rtl/map_bram_sdp.sv
// map_bram_sdp: parametrised simple-dual-port RAM for the mapper datapath.
// The write side takes byte-enabled writes from the key/value engines. The read side
// serves the reducer fetch logic with a 1- or 2-cycle latency and a read-valid pulse.
// When a read and a write hit the same address on the same edge, the read sees the new data.
// After reset, an optional sweep writes C_CLEAR_VAL into every entry before o_ready rises.

module map_bram_sdp #(
  parameter int                 C_WIDTH        = 32,
  parameter int                 C_LOG_DEPTH    = 4,
  parameter int                 C_OUT_REG      = 0,
  parameter int                 C_CLEAR_ON_RST = 1,
  parameter logic [C_WIDTH-1:0] C_CLEAR_VAL    = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [C_LOG_DEPTH-1:0]   i_waddr,
  input  logic                     i_wen,
  input  logic [C_WIDTH/8-1:0]     i_wbe,
  input  logic [C_WIDTH-1:0]       i_wdata,
  input  logic [C_LOG_DEPTH-1:0]   i_raddr,
  input  logic                     i_ce,
  output logic [C_WIDTH-1:0]       o_rdata,
  output logic                     o_rvalid,
  output logic                     o_ready
);

  localparam int C_DEPTH = 1 << C_LOG_DEPTH;
  localparam int C_LANES = C_WIDTH / 8;
  localparam logic [C_LOG_DEPTH-1:0] LAST_ADDR = '1;

  // Byte lanes only make sense for whole bytes, so refuse to elaborate otherwise.
  if ((C_WIDTH % 8 != 0) || (C_WIDTH < 8)) begin : g_width_check
    $error("map_bram_sdp: C_WIDTH (%0d) must be a non-zero multiple of 8", C_WIDTH);
  end

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t                   state;
  logic [C_LOG_DEPTH-1:0]   sweep_addr;
  logic [C_WIDTH-1:0]       mem [C_DEPTH];
  logic                     wr_fire;
  logic                     rd_fire;
  logic                     sweep_fire;
  logic [C_WIDTH-1:0]       rd_word;

  // User traffic is only honoured once the RAM is ready and not held in reset.
  assign wr_fire    = o_ready & i_wen & ~i_rst;
  assign rd_fire    = o_ready & i_ce & ~i_rst;
  assign sweep_fire = (state == S_CLEAR) & ~i_rst;

  // Sequencer: after reset, sweep every address once, then serve traffic until the next reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sweep_addr <= '0;
      if (C_CLEAR_ON_RST != 0) begin
        state   <= S_CLEAR;
        o_ready <= 1'b0;
      end else begin
        state   <= S_RUN;
        o_ready <= 1'b1;
      end
    end else begin
      unique case (state)
        S_CLEAR: begin
          sweep_addr <= sweep_addr + C_LOG_DEPTH'(1);
          if (sweep_addr == LAST_ADDR) begin
            state   <= S_RUN;
            o_ready <= 1'b1;
          end
        end
        S_RUN: begin
          o_ready <= 1'b1;
        end
      endcase
    end
  end

  // Single write port: clear-sweep writes take priority, otherwise byte-masked user writes.
  always_ff @(posedge i_clk) begin
    if (sweep_fire) begin
      mem[sweep_addr] <= C_CLEAR_VAL;
    end else if (wr_fire) begin
      for (int k = 0; k < C_LANES; k++) begin
        if (i_wbe[k]) begin
          mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
        end
      end
    end
  end

  // Write-first forwarding: on an address collision, patch the stored word with the enabled incoming lanes.
  always_comb begin
    rd_word = mem[i_raddr];
    for (int k = 0; k < C_LANES; k++) begin
      if (wr_fire && (i_waddr == i_raddr) && i_wbe[k]) begin
        rd_word[8*k +: 8] = i_wdata[8*k +: 8];
      end
    end
  end

  if (C_OUT_REG == 0) begin : g_lat1

    // One-cycle read: capture the (possibly forwarded) word directly into the output register.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        o_rvalid <= 1'b0;
        o_rdata  <= '0;
      end else begin
        o_rvalid <= rd_fire;
        if (rd_fire) begin
          o_rdata <= rd_word;
        end
      end
    end

  end else begin : g_lat2

    logic               s1_valid;
    logic [C_WIDTH-1:0] s1_data;

    // Two-cycle read: the middle stage decouples RAM output timing, and reset drops any read still in flight.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
        o_rvalid <= 1'b0;
        o_rdata  <= '0;
      end else begin
        s1_valid <= rd_fire;
        if (rd_fire) begin
          s1_data <= rd_word;
        end
        o_rvalid <= s1_valid;
        if (s1_valid) begin
          o_rdata <= s1_data;
        end
      end
    end

  end

endmodule
